assoc_read_cache: RTL and testbench

//  Parametrised N-way set-associative, read-only, blocking line cache between processor-side and DRAM-side Sysbus ports.

---
 rtl/assoc_cache_pkg.sv | 32 +++
 rtl/assoc_read_cache_lru.sv | 41 ++++
 rtl/assoc_read_cache.sv | 173 +++++++++++++++++
 tb/tb_assoc_read_cache.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_cache_pkg.sv
// Shared types and address-field geometry for the set-associative read cache.
package assoc_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_LOOKUP, S_MEMREQ, S_FILL, S_INSTALL, S_RESP
  } state_t;

  function automatic int off_w(input int bdw, input int beats);
    return $clog2(beats * bdw / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int bdw, input int sets, input int beats);
    return bdw - idx_w(sets) - off_w(bdw, beats);
  endfunction

  // Reference line/meta shapes at the default geometry (64b bus, 8 beats, 64 sets).
  localparam int DEF_BDW   = 64;
  localparam int DEF_BEATS = 8;
  localparam int DEF_SETS  = 64;

  typedef logic [DEF_BEATS-1:0][DEF_BDW-1:0] line_t;

  typedef struct packed {
    logic                                          valid;
    logic [tag_w(DEF_BDW, DEF_SETS, DEF_BEATS)-1:0] tag;
  } meta_t;

endpackage

// File: rtl/assoc_read_cache_lru.sv
// True-LRU age tracker: one age per way per set, oldest way (age WAYS-1) is the victim.
module lru_age_tracker #(
  parameter int WAYS = 4,
  parameter int SETS = 64,
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int IW = $clog2(SETS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          touch,
  input  logic [IW-1:0] touch_set,
  input  logic [AW-1:0] touch_way,
  input  logic [IW-1:0] victim_set,
  output logic [AW-1:0] victim_way
);

  logic [SETS-1:0][WAYS-1:0][AW-1:0] age;

  // Touched way becomes youngest; only ways younger than it age, so ages stay a permutation.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= AW'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AW'(w) == touch_way)
          age[touch_set][w] <= '0;
        else if (age[touch_set][w] < age[touch_set][touch_way])
          age[touch_set][w] <= age[touch_set][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[victim_set][w] == AW'(WAYS - 1)) victim_way = AW'(w);
  end

endmodule

// File: rtl/assoc_read_cache.sv
// N-way set-associative read-only line cache between processor and DRAM Sysbus ports.
// Define ASSOC_CACHE_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module assoc_read_cache
  import assoc_cache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int WAYS           = 4,
  parameter int SETS           = 64,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      p_bus_reqcyc,
  output logic                      p_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] p_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  p_bus_reqtag,
  output logic                      p_bus_respcyc,
  input  logic                      p_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] p_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  p_bus_resptag,
  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
`ifdef ASSOC_CACHE_STATS_EN
  output logic [31:0]               stat_hits,
  output logic [31:0]               stat_misses,
`endif
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag
);

  localparam int OW = off_w(BUS_DATA_WIDTH, LINE_BEATS);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(BUS_DATA_WIDTH, SETS, LINE_BEATS);
  localparam int PW = $clog2(LINE_BEATS);
  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [LINE_BEATS-1:0][BUS_DATA_WIDTH-1:0] line_lt;
  typedef struct packed {
    logic          valid;
    logic [TW-1:0] tag;
  } meta_lt;

  state_t                   state, state_nxt;
  logic [TW-1:0]            tag_q;
  logic [IW-1:0]            idx_q;
  logic [BUS_TAG_WIDTH-1:0] rtag_q;
  logic [PW-1:0]            ptr;
  line_lt                   line_q;
  line_lt                   data [SETS][WAYS];
  meta_lt                   meta [SETS][WAYS];

  logic [WAYS-1:0] hit_vec, inv_vec;
  logic [AW-1:0]   hit_way, inv_way, lru_way, vic_way;
  logic            hit, last, touch;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign hit_vec[w] = meta[idx_q][w].valid && (meta[idx_q][w].tag == tag_q);
    assign inv_vec[w] = !meta[idx_q][w].valid;
  end

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = AW'(w);
      if (inv_vec[w]) inv_way = AW'(w);
    end
  end

  assign hit     = |hit_vec;
  assign vic_way = (|inv_vec) ? inv_way : lru_way;
  assign last    = (ptr == PW'(LINE_BEATS - 1));
  assign touch   = (state == S_LOOKUP && hit) || (state == S_INSTALL);

  lru_age_tracker #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk       (clk),
    .reset     (reset),
    .touch     (touch),
    .touch_set (idx_q),
    .touch_way ((state == S_INSTALL) ? vic_way : hit_way),
    .victim_set(idx_q),
    .victim_way(lru_way)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    p_bus_reqack  = 1'b0;
    p_bus_respcyc = 1'b0;
    m_bus_reqcyc  = 1'b0;
    m_bus_respack = 1'b0;
    case (state)
      S_IDLE:    if (p_bus_reqcyc) state_nxt = S_ACK;
      S_ACK:     begin p_bus_reqack = 1'b1; state_nxt = S_LOOKUP; end
      S_LOOKUP:  state_nxt = hit ? S_RESP : S_MEMREQ;
      S_MEMREQ:  begin m_bus_reqcyc = 1'b1; if (m_bus_reqack) state_nxt = S_FILL; end
      S_FILL: begin
        m_bus_respack = m_bus_respcyc;
        if (m_bus_respcyc && last) state_nxt = S_INSTALL;
      end
      S_INSTALL: state_nxt = S_RESP;
      S_RESP: begin
        p_bus_respcyc = 1'b1;
        if (p_bus_respack && last) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign p_bus_resp    = p_bus_respcyc ? line_q[ptr] : '0;
  assign p_bus_resptag = rtag_q;
  assign m_bus_req     = m_bus_reqcyc ? {tag_q, idx_q, {OW{1'b0}}} : '0;
  assign m_bus_reqtag  = rtag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      tag_q  <= '0;
      idx_q  <= '0;
      rtag_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          meta[s][w].valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (p_bus_reqcyc) begin
          tag_q  <= p_bus_req[BUS_DATA_WIDTH-1 -: TW];
          idx_q  <= p_bus_req[OW +: IW];
          rtag_q <= p_bus_reqtag;
        end
        S_FILL:    if (m_bus_respcyc) ptr <= ptr + 1'b1;
        S_INSTALL: meta[idx_q][vic_way] <= '{valid: 1'b1, tag: tag_q};
        S_RESP:    if (p_bus_respack) ptr <= ptr + 1'b1;
        default: ;
      endcase
    end
  end

  // Line buffer doubles as fill staging and response source; storage needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && hit) line_q <= data[idx_q][hit_way];
    if (state == S_FILL && m_bus_respcyc) line_q[ptr] <= m_bus_resp;
    if (state == S_INSTALL) data[idx_q][vic_way] <= line_q;
  end

`ifdef ASSOC_CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 1'b1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      end
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = ^{m_bus_resptag, p_bus_req[OW-1:0]};

endmodule

// File: tb/tb_assoc_read_cache.sv
// Scoreboard bench for assoc_read_cache: behavioural DRAM plus per-scenario read tasks.
module tb_assoc_read_cache;
  localparam int BDW = 64;
  localparam int BTW = 13;

  logic           clk = 1'b0;
  logic           reset;
  logic           p_bus_reqcyc, p_bus_reqack, p_bus_respcyc, p_bus_respack;
  logic [BDW-1:0] p_bus_req, p_bus_resp;
  logic [BTW-1:0] p_bus_reqtag, p_bus_resptag;
  logic           m_bus_reqcyc, m_bus_reqack, m_bus_respcyc, m_bus_respack;
  logic [BDW-1:0] m_bus_req, m_bus_resp;
  logic [BTW-1:0] m_bus_reqtag, m_bus_resptag;
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0]    stat_hits, stat_misses;
`endif

  assoc_read_cache dut (
    .clk(clk), .reset(reset),
    .p_bus_reqcyc(p_bus_reqcyc), .p_bus_reqack(p_bus_reqack), .p_bus_req(p_bus_req),
    .p_bus_reqtag(p_bus_reqtag), .p_bus_respcyc(p_bus_respcyc), .p_bus_respack(p_bus_respack),
    .p_bus_resp(p_bus_resp), .p_bus_resptag(p_bus_resptag),
    .m_bus_reqcyc(m_bus_reqcyc), .m_bus_reqack(m_bus_reqack), .m_bus_req(m_bus_req),
    .m_bus_reqtag(m_bus_reqtag), .m_bus_respcyc(m_bus_respcyc), .m_bus_respack(m_bus_respack),
    .m_bus_resp(m_bus_resp),
`ifdef ASSOC_CACHE_STATS_EN
    .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
    .m_bus_resptag(m_bus_resptag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [BDW-1:0] exp_q[$];
  logic [BDW-1:0] mreq_q[$];
  int mreqs = 0, mphase = 0, mbeat = 0;
  bit mtook = 1'b0;
  logic [BDW-1:0] maddr;
  int exp_hits = 0, exp_misses = 0;

  function automatic logic [BDW-1:0] mdata(input logic [BDW-1:0] la, input int b);
    return 64'hDA7A_0000_0000_0000 ^ (la << 8) ^ BDW'(b);
  endfunction

  // DRAM model: acks one cycle after request, then streams 8 beats; acts at negedge+1.
  initial begin
    m_bus_reqack = 1'b0; m_bus_respcyc = 1'b0; m_bus_resp = '0; m_bus_resptag = 13'h1abc;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        m_bus_reqack = 1'b0; m_bus_respcyc = 1'b0; mphase = 0; mtook = 1'b0;
      end else begin
        case (mphase)
          0: if (m_bus_reqcyc) begin
            maddr = m_bus_req; mreq_q.push_back(m_bus_req); mreqs++;
            m_bus_reqack = 1'b1; mphase = 1;
          end
          1: begin
            m_bus_reqack = 1'b0; mbeat = 0; m_bus_respcyc = 1'b1;
            m_bus_resp = mdata(maddr, 0); mphase = 2;
          end
          2: if (mtook) begin
            mbeat++;
            if (mbeat == 8) begin m_bus_respcyc = 1'b0; mphase = 0; end
            else m_bus_resp = mdata(maddr, mbeat);
          end
          default: mphase = 0;
        endcase
      end
      #1 mtook = m_bus_respcyc && m_bus_respack;
    end
  end

  task automatic read_line(input logic [BDW-1:0] a, input logic [BTW-1:0] t, input bit exp_miss,
                           input int stall_beat, input int stall_n, input bit chain,
                           input logic [BDW-1:0] na, output int lat);
    logic [BDW-1:0] la;
    int m0, cyc, beat, stalls;
    bit acked;
    la = a & ~64'h3F;
    for (int b = 0; b < 8; b++) exp_q.push_back(mdata(la, b));
    if (exp_miss) exp_misses++; else exp_hits++;
    m0 = mreqs;
    if (!p_bus_reqcyc) begin
      @(negedge clk);
      p_bus_reqcyc = 1'b1; p_bus_req = a; p_bus_reqtag = t;
    end
    p_bus_respack = 1'b1;
    lat = -1; cyc = 0; beat = 0; stalls = 0; acked = 1'b0;
    while (beat < 8 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (p_bus_reqack) begin p_bus_reqcyc = 1'b0; acked = 1'b1; end
      if (stalls > 0 && beat == stall_beat) begin
        checks++;
        if (p_bus_respcyc !== 1'b1) begin
          errors++; $display("FAIL stall_respcyc addr=%h got=%b want=1", a, p_bus_respcyc);
        end
      end
      if (p_bus_respcyc) begin
        if (lat < 0) lat = cyc;
        checks++;
        if (p_bus_resp !== exp_q[0]) begin
          errors++; $display("FAIL resp addr=%h beat=%0d got=%h want=%h", a, beat, p_bus_resp, exp_q[0]);
        end
        checks++;
        if (p_bus_resptag !== t) begin
          errors++; $display("FAIL resptag addr=%h got=%h want=%h", a, p_bus_resptag, t);
        end
        if (beat == stall_beat && stalls < stall_n) begin
          p_bus_respack = 1'b0; stalls++;
        end else begin
          p_bus_respack = 1'b1; void'(exp_q.pop_front()); beat++;
          if (beat == 8 && chain) begin
            p_bus_reqcyc = 1'b1; p_bus_req = na; p_bus_reqtag = t + 13'd1;
          end
        end
      end
    end
    if (beat < 8) begin
      errors++; $display("FAIL timeout addr=%h beats=%0d want=8", a, beat);
      exp_q.delete();
    end
    checks++;
    if (!acked) begin errors++; $display("FAIL reqack addr=%h got=0 want=1", a); end
    checks++;
    if ((mreqs - m0 == 1) !== exp_miss) begin
      errors++; $display("FAIL miss addr=%h got=%0d want=%0d", a, mreqs - m0, exp_miss);
    end
    if (exp_miss && mreq_q.size() > 0) begin
      logic [BDW-1:0] got;
      got = mreq_q.pop_front();
      checks++;
      if (got !== la) begin errors++; $display("FAIL m_bus_req got=%h want=%h", got, la); end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({p_bus_reqack, p_bus_respcyc, m_bus_reqcyc, m_bus_respack} !== 4'b0) begin
      errors++; $display("FAIL %s_ctrl got=%b want=0000", name,
                         {p_bus_reqack, p_bus_respcyc, m_bus_reqcyc, m_bus_respack});
    end
    checks++;
    if ({p_bus_resp, m_bus_req, p_bus_resptag, m_bus_reqtag} !== '0) begin
      errors++; $display("FAIL %s_data got resp=%h mreq=%h rtag=%h mtag=%h want=0", name,
                         p_bus_resp, m_bus_req, p_bus_resptag, m_bus_reqtag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    exp_hits = 0; exp_misses = 0;
  endtask

  task automatic test_cold_miss();
    int lat;
    read_line(64'h1000, 13'h005, 1'b1, -1, 0, 1'b0, '0, lat);
  endtask

  task automatic test_hit();
    int lat;
    read_line(64'h1008, 13'h006, 1'b0, -1, 0, 1'b0, '0, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL hit_latency got=%0d want=3", lat); end
  endtask

  task automatic test_eviction();
    int lat;
    read_line(64'h0000, 13'h010, 1'b1, -1, 0, 1'b0, '0, lat);
    read_line(64'h1000, 13'h011, 1'b0, -1, 0, 1'b0, '0, lat);
    read_line(64'h2000, 13'h012, 1'b1, -1, 0, 1'b0, '0, lat);
    read_line(64'h3000, 13'h013, 1'b1, -1, 0, 1'b0, '0, lat);
    read_line(64'h4000, 13'h014, 1'b1, -1, 0, 1'b0, '0, lat);
    read_line(64'h1000, 13'h015, 1'b0, -1, 0, 1'b0, '0, lat);
    read_line(64'h0000, 13'h016, 1'b1, -1, 0, 1'b0, '0, lat);
  endtask

  task automatic test_stall();
    int lat;
    read_line(64'h1020, 13'h0aa, 1'b0, 3, 10, 1'b0, '0, lat);
  endtask

  task automatic test_reset_mid_fill();
    int cyc, lat;
    bit hit4;
    @(negedge clk);
    p_bus_reqcyc = 1'b1; p_bus_req = 64'h6000; p_bus_reqtag = 13'h077;
    cyc = 0; hit4 = 1'b0;
    while (!hit4 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (p_bus_reqack) p_bus_reqcyc = 1'b0;
      #3;
      if (mphase == 2 && mbeat == 4) hit4 = 1'b1;
    end
    checks++;
    if (!hit4) begin errors++; $display("FAIL fill_beat4_timeout got=%0d want=reach", cyc); end
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_fill");
    #3 reset = 1'b0;
    p_bus_reqcyc = 1'b0;
    exp_q.delete(); mreq_q.delete();
    exp_hits = 0; exp_misses = 0;
    read_line(64'h1000, 13'h078, 1'b1, -1, 0, 1'b0, '0, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    read_line(64'h1000, 13'h100, 1'b0, -1, 0, 1'b1, 64'h1030, lat);
    read_line(64'h1030, 13'h101, 1'b0, -1, 0, 1'b0, '0, lat);
    checks++;
    if (lat != 4) begin errors++; $display("FAIL chained_latency got=%0d want=4", lat); end
  endtask

  task automatic test_stats();
`ifdef ASSOC_CACHE_STATS_EN
    @(negedge clk);
    checks++;
    if (stat_hits !== 32'(exp_hits)) begin
      errors++; $display("FAIL stat_hits got=%0d want=%0d", stat_hits, exp_hits);
    end
    checks++;
    if (stat_misses !== 32'(exp_misses)) begin
      errors++; $display("FAIL stat_misses got=%0d want=%0d", stat_misses, exp_misses);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; p_bus_reqcyc = 1'b0; p_bus_req = '0; p_bus_reqtag = '0; p_bus_respack = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_eviction();
    test_stall();
    test_reset_mid_fill();
    test_back_to_back();
    test_stats();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
